axi_stream_insert_header: RTL and testbench
===========================================

Name: axi_stream_insert_header

Overview:
AXI-Stream header inserter. It accepts one header word per packet on a dedicated header channel and prepends its valid bytes to the following data packet. The merged stream is re-packed into full, byte-contiguous beats. It sits between a packet source and a downstream AXI-Stream sink.

Parameters:
DATA_WD, 32, data/header width in bits (multiple of 8)
DATA_BYTE_WD, DATA_WD/8, bytes per beat
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the name)
valid_in  in  1  data beat valid
data_in  in  DATA_WD  data beat; byte 3 ([31:24]) is the first byte in stream order
keep_in  in  DATA_BYTE_WD  byte enables. All ones on non-last beats; left-aligned on the last beat (1000/1100/1110/1111).
last_in  in  1  last data beat of packet
ready_in  out  1  data beat accepted when valid_in && ready_in
valid_out  out  1  output beat valid
data_out  out  DATA_WD  output beat, same byte order as data_in
keep_out  out  DATA_BYTE_WD  output byte enables. All ones except possibly the last beat, which is left-aligned.
last_out  out  1  last output beat of packet
ready_out  in  1  downstream ready
valid_insert  in  1  header valid
data_insert  in  DATA_WD  header word; valid bytes are right-aligned
keep_insert  in  DATA_BYTE_WD  header enables, right-aligned (0001/0011/0111/1111)
byte_insert_cnt  in  BYTE_CNT_WD  informational header byte count; ignored, keep_insert is authoritative
ready_insert  out  1  header accepted when valid_insert && ready_insert
data_word_cnt  out  DATA_WD  count of output beats transferred in the current/most recent packet

Behaviour:
- Reset (rst_n=1 at clk edge): state=IDLE, valid_out=0, last_out=0, keep_out=0, data_out=0, residual count=0, data_word_cnt=0. Reset mid-packet discards the packet, including any buffered bytes.
- States:
  - IDLE: ready_insert=1, ready_in=0. On header handshake, load residual buffer with the H valid header bytes; H = popcount(keep_insert), 1..4. Clear data_word_cnt. Go to DATA.
  - DATA: ready_insert=0. ready_in = !flush_pending && (!valid_out || ready_out).
  - FLUSH: internal pending-beat flag within DATA; ready_in=0.
- Packing:
  - On each accepted data beat with B bytes (B=4 non-last; popcount(keep_in) on last), form the concatenation {residual R bytes, B data bytes}; total T = R + B.
  - If T >= 4: emit the first 4 bytes with keep_out=1111. New residual = the remaining T-4 bytes.
  - If T < 4 (last beat only): emit T bytes left-aligned, keep_out left-aligned, last_out=1.
  - On the last beat with T = 4: last_out=1, residual 0.
  - On the last beat with T > 4: the emitted beat has last_out=0. Set flush_pending; the next output slot emits the residual T-4 bytes left-aligned with last_out=1.
- Return to IDLE when the packet's last output beat is loaded into the output register.
- Output register: single stage. The beat appears on the cycle after the input handshake (1-cycle latency). data_out, keep_out and last_out are held stable while valid_out && !ready_out. valid_out clears on ready_out when no new beat is loaded.
- Throughput: one beat per cycle when ready_out=1. Only an H+B overflow on the last beat costs one extra cycle.
- data_word_cnt increments on each valid_out && ready_out. It holds its value after last_out until the next header handshake.
- valid_in while in IDLE is ignored (ready_in=0). Likewise valid_insert during DATA is ignored.
- keep_out outside valid beats = 0.

Test Plan:
- Header 0x0000AABB keep_insert 0011, data 0x11223344 (keep 1111), then last 0x5566xxxx keep 1100, ready_out=1 -> out 0xAABB1122 keep 1111, then 0x33445566 keep 1111 last_out=1; data_word_cnt=2.
- Header 0xDDCCBBAA keep_insert 1111, single last beat 0x1234xxxx keep 1100 -> 0xDDCCBBAA keep 1111, then flush 0x1234xxxx keep 1100 last_out=1; ready_in=0 during flush.
- Header keep_insert 0001 (0x000000EE), beats 0x01020304, last 0x050607xx keep 1110 -> 0xEE010203, 0x04050607 last keep 1111.
- Backpressure: scenario 1 with ready_out toggling 0/1 every cycle -> identical output sequence; outputs stable while stalled; ready_in=0 when valid_out && !ready_out.
- Back-to-back packets with valid_insert held high -> ready_insert=1 only in IDLE; second header accepted after first packet's last beat loads; data_word_cnt resets to 0.
- Assert rst_n mid-packet -> next edge: valid_out=0, ready_insert=1, ready_in=0; next packet correct.

Source files
------------

// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends the valid bytes of one header word to each
// packet and re-packs the merged byte stream into full, left-aligned output beats.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic [DATA_WD-1:0]      data_word_cnt
);
  localparam int RCNT_WD = BYTE_CNT_WD + 1;  // residual byte count, 0..DATA_BYTE_WD
  localparam int TCNT_WD = BYTE_CNT_WD + 2;  // residual + beat bytes, 0..2*DATA_BYTE_WD

  typedef enum logic {IDLE, DATA} state_t;

  state_t                  state, state_next;
  logic                    flush_pending, flush_next;
  logic [DATA_WD-1:0]      res_data, res_data_next;   // left-aligned leftover bytes
  logic [RCNT_WD-1:0]      res_cnt, res_cnt_next;
  logic                    slot_free;
  logic [RCNT_WD-1:0]      beat_bytes, hdr_bytes;
  logic [TCNT_WD-1:0]      total;
  logic [DATA_WD-1:0]      beat_masked, hdr_aligned;
  logic [2*DATA_WD-1:0]    merged;
  logic                    load, load_last;
  logic [DATA_WD-1:0]      load_data;
  logic [DATA_BYTE_WD-1:0] load_keep;

  // The header byte count is informational only; keep_insert is authoritative.
  logic unused_byte_cnt;
  assign unused_byte_cnt = ^byte_insert_cnt;

  function automatic logic [RCNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    popcount = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) popcount = popcount + RCNT_WD'(k[i]);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] left_mask(input logic [RCNT_WD-1:0] n);
    left_mask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < int'(n)) left_mask[DATA_BYTE_WD-1-i] = 1'b1;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    for (int i = 0; i < DATA_BYTE_WD; i++) byte_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  assign slot_free    = !valid_out || ready_out;
  assign ready_insert = (state == IDLE);
  assign ready_in     = (state == DATA) && !flush_pending && slot_free;

  // Residual bytes sit at the top of the merged word; the new beat lands right behind them.
  assign beat_bytes  = last_in ? popcount(keep_in) : RCNT_WD'(DATA_BYTE_WD);
  assign beat_masked = data_in & byte_mask(left_mask(beat_bytes));
  assign merged      = {res_data, {DATA_WD{1'b0}}}
                     | ({beat_masked, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
  assign total       = TCNT_WD'(res_cnt) + TCNT_WD'(beat_bytes);
  assign hdr_bytes   = popcount(keep_insert);
  assign hdr_aligned = (data_insert & byte_mask(keep_insert))
                     << {(RCNT_WD'(DATA_BYTE_WD) - hdr_bytes), 3'b000};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next    = state;
    flush_next    = flush_pending;
    res_data_next = res_data;
    res_cnt_next  = res_cnt;
    load          = 1'b0;
    load_data     = merged[2*DATA_WD-1 -: DATA_WD];
    load_keep     = '1;
    load_last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_insert) begin
          state_next    = DATA;
          flush_next    = 1'b0;
          res_data_next = hdr_aligned;
          res_cnt_next  = hdr_bytes;
        end
      end
      DATA: begin
        if (flush_pending) begin
          if (slot_free) begin
            load          = 1'b1;
            load_data     = res_data;
            load_keep     = left_mask(res_cnt);
            load_last     = 1'b1;
            flush_next    = 1'b0;
            res_data_next = '0;
            res_cnt_next  = '0;
            state_next    = IDLE;
          end
        end else if (valid_in && ready_in) begin
          load          = 1'b1;
          res_data_next = merged[DATA_WD-1:0];
          res_cnt_next  = RCNT_WD'(total - TCNT_WD'(DATA_BYTE_WD));
          if (last_in) begin
            if (total > TCNT_WD'(DATA_BYTE_WD)) begin
              flush_next = 1'b1;
            end else begin
              load_last     = 1'b1;
              load_keep     = left_mask(RCNT_WD'(total));
              res_data_next = '0;
              res_cnt_next  = '0;
              state_next    = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples the same edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      res_data      <= '0;
      res_cnt       <= '0;
      valid_out     <= 1'b0;
      data_out      <= '0;
      keep_out      <= '0;
      last_out      <= 1'b0;
      data_word_cnt <= '0;
    end else begin
      state         <= state_next;
      flush_pending <= flush_next;
      res_data      <= res_data_next;
      res_cnt       <= res_cnt_next;
      if (load) begin
        valid_out <= 1'b1;
        data_out  <= load_data;
        keep_out  <= load_keep;
        last_out  <= load_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
        keep_out  <= '0;
        last_out  <= 1'b0;
      end
      if (valid_insert && ready_insert) data_word_cnt <= '0;
      else if (valid_out && ready_out)  data_word_cnt <= data_word_cnt + DATA_WD'(1);
    end
  end
endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Self-checking bench for axi_stream_insert_header: directed vector table, hand-written
// corner sequences, and random packets checked against a byte-queue reference model.
`timescale 1ns/1ps
module tb_axi_stream_insert_header;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in, valid_out, last_out, ready_out;
  logic [31:0] data_in, data_out, data_insert, data_word_cnt;
  logic [3:0]  keep_in, keep_out, keep_insert;
  logic [1:0]  byte_insert_cnt;
  logic        valid_insert, ready_insert;

  always #5 clk = ~clk;

  axi_stream_insert_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .data_word_cnt(data_word_cnt)
  );

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct { logic [31:0] data; logic [3:0] keep; int prev_out; } hdr_t;
  typedef struct {
    logic [31:0] hdr; logic [3:0] hkeep;
    int nin; logic [31:0] din[4]; logic [3:0] lkeep;
    int nout; logic [31:0] dout[4]; logic [3:0] kout[4];
    logic [31:0] cnt; int mode;
  } vec_t;

  beat_t beat_q[$], exp_q[$];
  hdr_t  hdr_q[$];
  vec_t  vecs[7];
  int tests = 0, fails = 0;
  int rdy_mode, gap_en, n_rx, tot_out;
  logic in_hold, hdr_hold, prev_stall, hs_prev, prev_last;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{k[i]}};
  endfunction

  function automatic logic [3:0] lkeep(input int n);
    logic [3:0] f;
    f = 4'hF << (4 - n);
    return f;
  endfunction

  function automatic logic [3:0] rkeep(input int n);
    logic [3:0] f;
    f = 4'hF >> (4 - n);
    return f;
  endfunction

  // Reference model: header bytes then data bytes as one byte list, cut into 4-byte beats.
  task automatic push_packet(input logic [31:0] hd, input int h, input byte unsigned d[$]);
    byte unsigned all[$];
    hdr_t  hh;
    beat_t b;
    int    n;
    hh.data = hd; hh.keep = rkeep(h); hh.prev_out = tot_out;
    hdr_q.push_back(hh);
    for (int i = h - 1; i >= 0; i--) all.push_back(hd[8*i +: 8]);
    foreach (d[i]) all.push_back(d[i]);
    for (int i = 0; i < d.size(); i += 4) begin
      n = (d.size() - i < 4) ? d.size() - i : 4;
      b.data = '0;
      for (int j = 0; j < n; j++) b.data[31-8*j -: 8] = d[i+j];
      b.keep = lkeep(n);
      b.data = b.data | ($urandom & ~bmask(b.keep));
      b.last = (i + 4 >= d.size());
      beat_q.push_back(b);
    end
    for (int i = 0; i < all.size(); i += 4) begin
      n = (all.size() - i < 4) ? all.size() - i : 4;
      b.data = '0;
      for (int j = 0; j < n; j++) b.data[31-8*j -: 8] = all[i+j];
      b.keep = lkeep(n);
      b.last = (i + 4 >= all.size());
      exp_q.push_back(b);
      tot_out++;
    end
  endtask

  task automatic begin_run();
    n_rx = 0; tot_out = 0;
    in_hold = 0; hdr_hold = 0; prev_stall = 0; hs_prev = 0;
  endtask

  // One clock cycle: drive at the falling edge, observe handshakes and invariants 1 ns later.
  task automatic step();
    beat_t e;
    hdr_t  h;
    int    loaded;
    @(negedge clk);
    case (rdy_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = ~ready_out;
      default: ready_out = 1'($urandom_range(1));
    endcase
    if (!hdr_hold) valid_insert = (hdr_q.size() > 0) && (gap_en == 0 || $urandom_range(2) != 0);
    if (hdr_q.size() > 0) begin
      data_insert = hdr_q[0].data; keep_insert = hdr_q[0].keep; byte_insert_cnt = 2'($urandom);
    end
    if (!in_hold) valid_in = (beat_q.size() > 0) && (gap_en == 0 || $urandom_range(2) != 0);
    if (beat_q.size() > 0) begin
      data_in = beat_q[0].data; keep_in = beat_q[0].keep; last_in = beat_q[0].last;
    end
    #1;
    if (prev_stall) begin
      check("stall_valid", valid_out, 1);
      check("stall_data", data_out, prev_data);
      check("stall_keep", keep_out, prev_keep);
      check("stall_last", last_out, prev_last);
    end
    if (valid_out && !ready_out) check("stall_ready_in", ready_in, 0);
    if (!valid_out) check("idle_keep_out", keep_out, 0);
    if (hs_prev) check("cnt_clear_on_header", data_word_cnt, 0);
    check("ready_exclusive", ready_in & ready_insert, 0);
    loaded = n_rx + (valid_out ? 1 : 0);
    hs_prev = 0;
    if (valid_insert && ready_insert) begin
      h = hdr_q.pop_front();
      check("header_after_last_load", loaded, h.prev_out);
      hs_prev = 1;
    end
    if (valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_beat: got 0x%08h, expected no beat", data_out);
      end else begin
        e = exp_q.pop_front();
        check("out_data", data_out & bmask(e.keep), e.data & bmask(e.keep));
        check("out_keep", keep_out, e.keep);
        check("out_last", last_out, e.last);
      end
      n_rx++;
    end
    if (valid_in && ready_in) void'(beat_q.pop_front());
    hdr_hold   = valid_insert && !ready_insert;
    in_hold    = valid_in && !ready_in;
    prev_stall = valid_out && !ready_out;
    prev_data  = data_out; prev_keep = keep_out; prev_last = last_out;
  endtask

  task automatic run(input int budget);
    int cyc = 0;
    while ((exp_q.size() > 0 || beat_q.size() > 0 || hdr_q.size() > 0) && cyc < budget) begin
      step();
      cyc++;
    end
    if (cyc >= budget) begin
      tests++; fails++;
      $display("FAIL timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete(); beat_q.delete(); hdr_q.delete();
      valid_in = 0; valid_insert = 0;
      rst_n = 1; @(negedge clk); rst_n = 0;
    end
    step();
    check("drained_valid_out", valid_out, 0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    hdr_t  hh;
    beat_t b;
    begin_run();
    rdy_mode = v.mode; gap_en = 0;
    hh.data = v.hdr; hh.keep = v.hkeep; hh.prev_out = 0;
    hdr_q.push_back(hh);
    for (int i = 0; i < v.nin; i++) begin
      b.data = v.din[i]; b.keep = (i == v.nin - 1) ? v.lkeep : 4'hF; b.last = (i == v.nin - 1);
      beat_q.push_back(b);
    end
    for (int j = 0; j < v.nout; j++) begin
      b.data = v.dout[j]; b.keep = v.kout[j]; b.last = (j == v.nout - 1);
      exp_q.push_back(b);
    end
    tot_out = v.nout;
    run(2000);
    check({tag, "_word_cnt"}, data_word_cnt, v.cnt);
  endtask

  task automatic push_random();
    byte unsigned d[$];
    int len;
    len = $urandom_range(12, 1);
    for (int i = 0; i < len; i++) d.push_back(8'($urandom));
    push_packet($urandom, $urandom_range(4, 1), d);
  endtask

  initial begin
    vecs[0] = '{32'h0000AABB, 4'b0011, 2, '{32'h11223344, 32'h55660000, 0, 0}, 4'b1100,
                2, '{32'hAABB1122, 32'h33445566, 0, 0}, '{4'hF, 4'hF, 0, 0}, 2, 0};
    vecs[1] = '{32'hDDCCBBAA, 4'b1111, 1, '{32'h12340000, 0, 0, 0}, 4'b1100,
                2, '{32'hDDCCBBAA, 32'h12340000, 0, 0}, '{4'hF, 4'hC, 0, 0}, 2, 0};
    vecs[2] = '{32'h000000EE, 4'b0001, 2, '{32'h01020304, 32'h05060700, 0, 0}, 4'b1110,
                2, '{32'hEE010203, 32'h04050607, 0, 0}, '{4'hF, 4'hF, 0, 0}, 2, 0};
    vecs[3] = vecs[0];
    vecs[3].mode = 1;
    vecs[4] = '{32'h000000AB, 4'b0001, 1, '{32'hCD000000, 0, 0, 0}, 4'b1000,
                1, '{32'hABCD0000, 0, 0, 0}, '{4'hC, 0, 0, 0}, 1, 0};
    vecs[5] = '{32'h0000BEEF, 4'b0011, 1, '{32'hCAFE0000, 0, 0, 0}, 4'b1100,
                1, '{32'hBEEFCAFE, 0, 0, 0}, '{4'hF, 0, 0, 0}, 1, 1};
    vecs[6] = '{32'h01020304, 4'b1111, 3, '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1000000, 0}, 4'b1000,
                4, '{32'h01020304, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1000000}, '{4'hF, 4'hF, 4'hF, 4'h8}, 4, 2};

    valid_in = 0; data_in = 0; keep_in = 0; last_in = 0; ready_out = 1;
    valid_insert = 0; data_insert = 0; keep_insert = 0; byte_insert_cnt = 0;
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_keep_out", keep_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_word_cnt", data_word_cnt, 0);
    check("rst_ready_insert", ready_insert, 1);
    check("rst_ready_in", ready_in, 0);
    rst_n = 0;

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Overflow on a lone last beat: ready_in must drop while the flush beat is pending.
    @(negedge clk);
    ready_out = 1; valid_insert = 1; data_insert = 32'hDDCCBBAA; keep_insert = 4'hF;
    #1 check("flush_hdr_ready", ready_insert, 1);
    @(negedge clk);
    valid_insert = 0; valid_in = 1; data_in = 32'h1234BEEF; keep_in = 4'hC; last_in = 1;
    #1 check("flush_beat_ready", ready_in, 1);
    @(negedge clk);
    valid_in = 0;
    #1;
    check("flush_ready_in_low", ready_in, 0);
    check("flush_first_data", data_out, 32'hDDCCBBAA);
    check("flush_first_last", last_out, 0);
    @(negedge clk);
    #1;
    check("flush_second_data", data_out & 32'hFFFF0000, 32'h12340000);
    check("flush_second_keep", keep_out, 4'hC);
    check("flush_second_last", last_out, 1);
    check("flush_idle_ready_insert", ready_insert, 1);

    // Reset in the middle of a stalled packet with a buffered residual byte.
    @(negedge clk);
    ready_out = 0; valid_insert = 1; data_insert = 32'h000000FF; keep_insert = 4'b0001;
    @(negedge clk);
    valid_insert = 0; valid_in = 1; data_in = 32'h11111111; keep_in = 4'hF; last_in = 0;
    @(negedge clk);
    valid_in = 0;
    check("midrst_pre_valid", valid_out, 1);
    rst_n = 1;
    @(negedge clk);
    check("midrst_valid_out", valid_out, 0);
    check("midrst_ready_insert", ready_insert, 1);
    check("midrst_ready_in", ready_in, 0);
    check("midrst_keep_out", keep_out, 0);
    rst_n = 0;
    apply_vec(vecs[0], "after_rst");

    // Back-to-back packets with the header valid held high.
    begin_run(); rdy_mode = 0; gap_en = 0;
    for (int p = 0; p < 3; p++) push_random();
    run(2000);

    // Random packets, random gaps and random backpressure.
    for (int r = 0; r < 6; r++) begin
      begin_run(); rdy_mode = $urandom_range(2); gap_en = 1;
      for (int p = 0; p < 8; p++) push_random();
      run(4000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
